// File: rtl/seq_div_restoring_if.sv
// Start/busy/done handshake and operand/result bus between a controller and
// the restoring divider.
interface seq_div_restoring_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_restoring.sv
// Multi-cycle unsigned restoring divider: one shift-and-trial-subtract per
// clock, results registered and held until the next completion.
module seq_div_restoring #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_div_restoring_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             dz_q;
    logic [CW-1:0]    cnt_q;
    logic             load, zero_div, step, finish;

    // The shifted-out remainder MSB takes part in the compare, so a partial
    // remainder of WIDTH+1 bits never loses a quotient bit.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] rs;
        rs = {r, q[WIDTH-1]};
        if (rs >= {1'b0, d})
            div_step = {rs[WIDTH-1:0] - d, q[WIDTH-2:0], 1'b1};
        else
            div_step = {rs[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        zero_div = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (bus.divisor == '0) begin
                        zero_div = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // One settling cycle after the last iteration publishes results.
                if (cnt_q == LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else if (load) begin
            r_q   <= '0;
            q_q   <= bus.dividend;
            d_q   <= bus.divisor;
            cnt_q <= '0;
            if (zero_div) begin
                quot_q <= '1;
                rem_q  <= bus.dividend;
                dz_q   <= 1'b1;
            end
        end else if (step) begin
            {r_q, q_q} <= div_step(r_q, q_q, d_q);
            cnt_q      <= cnt_q + CW'(1);
        end else if (finish) begin
            quot_q <= q_q;
            rem_q  <= r_q;
            dz_q   <= 1'b0;
        end
    end

    assign bus.busy        = (state_q == RUN) && (cnt_q != LAST);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: doc/seq_div_restoring.md
# seq_div_restoring

Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the combinational 4-bit adder/subtractor: where that block produces `A+B` or `A-B` with carry/borrow, this block recovers quotient and remainder from `dividend / divisor`. It does this by repeated shift-and-trial-subtract, using the subtractor's borrow to decide each quotient bit. The block sits beside the add/sub datapath and presents a start/busy/done handshake to its controller.

## Interface
- `WIDTH`, default 4: operand and result width in bits, ≥ 2.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division; sampled only when `busy`=0.
- `dividend`  in  WIDTH  unsigned numerator; sampled with `start`.
- `divisor`  in  WIDTH  unsigned denominator; sampled with `start`.
- `busy`  out  1  high while an iteration is in progress.
- `done`  out  1  one-cycle pulse; results valid from this cycle on.
- `quotient`  out  WIDTH  registered quotient; holds until the next completion.
- `remainder`  out  WIDTH  registered remainder; holds until the next completion.
- `div_by_zero`  out  1  set with `done` when `divisor`=0; holds until the next completion.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE or DONE with `start`=1:** latch the operands. Set working remainder R = 0 (WIDTH bits) and working quotient Q = `dividend`, and clear the iteration count.
  - If `divisor`≠0, go to RUN.
  - If `divisor`=0, go to DONE with `quotient`=all ones, `remainder`=`dividend` and `div_by_zero`=1.
- **DONE with `start`=0:** return to IDLE.
- **IDLE with `start`=0:** stay in IDLE.
- **RUN iteration (every cycle):**
  - Shift {R,Q} left by 1.
  - Compute trial T = {1'b0,R} − {1'b0,divisor} in WIDTH+1 bits; T[WIDTH] is the borrow.
  - Borrow=0: R = T[WIDTH-1:0], Q[0] = 1.
  - Borrow=1: R unchanged, Q[0] = 0.
  - R must be kept WIDTH+1 bits internally, or the shifted-out MSB must be included in the trial, so that no borrow decision is lost.
- **End of RUN:** after exactly WIDTH iterations, copy Q→`quotient` and R→`remainder`, clear `div_by_zero`, and go to DONE.
- **Outputs during RUN:** `quotient`, `remainder` and `div_by_zero` are not disturbed; they change only on entry to DONE.
- **Ignored `start`:** `start` while in RUN is ignored; operands are not re-sampled.
- **Invariant:** `quotient`·`divisor` + `remainder` = `dividend` and `remainder` < `divisor` for every `divisor`≠0.

## Timing
- **Reset:** `rst_n`=0 immediately forces IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, and clears all working registers and the count.
  - A reset during RUN aborts the operation; no `done` is produced.
  - Operation resumes on the first rising edge with `rst_n`=1.
- **Normal latency:** `start` sampled at edge k. `busy`=1 for the WIDTH cycles following edges k … k+WIDTH−1. `done`=1 for exactly one cycle, after edge k+WIDTH+1, with the results already valid in that cycle.
  - For WIDTH=4 this is 5 edges from the start edge to the done cycle.
- **Divide-by-zero latency:** `done`=1 in the cycle after edge k; `busy` never asserts.
- **Back-to-back:** `start` held high during the DONE cycle is accepted at the next edge, giving 0 idle cycles between operations.
  - `done` for the new operation is still a separate pulse.
  - The previous results stay visible until the new completion.
- **Exclusivity:** `busy` and `done` are never high together.

## Test plan
- Reset → all outputs 0. Then `dividend`=10, `divisor`=3, `start` pulse → `busy` high 4 cycles, then `done` pulse with `quotient`=3, `remainder`=1, `div_by_zero`=0.
- 15/15 → q=1, r=0. 4/7 → q=0, r=4. 15/1 → q=15, r=0. 9/2 → q=4, r=1. Each with the exact latency of 5 edges from the start edge to the done cycle.
- 9/0 → `done` in the cycle after the start edge, `quotient`=15, `remainder`=9, `div_by_zero`=1, `busy` never high. A following 6/4 → q=1, r=2, `div_by_zero` cleared.
- Start 12/5, then pulse `start` with 1/1 during RUN → ignored; result q=2, r=2. Outputs hold their previous values throughout RUN.
- Assert `rst_n` low mid-RUN on 13/3 → all outputs 0 immediately and no `done`. After release, 13/3 → q=4, r=1.
- Exhaustive sweep of all 256 dividend/divisor pairs at WIDTH=4, back-to-back with `start` held high → every result matches the reference model, `done` count = 256, and `busy`/`done` are never high together.
